// File: rtl/flappy_sprite_pkg.sv
// Shared sizes, types and address helper for the sprite row fetcher.
package flappy_sprite_pkg;
  localparam int SPR_W       = 17;
  localparam int SPR_H       = 12;
  localparam int FRAMES      = 3;
  localparam int ADDR_W      = 10;
  localparam int PIX_W       = 6;
  localparam int COORD_W     = 10;
  localparam int FRAME_WORDS = SPR_W * SPR_H;
  localparam int COL_W       = $clog2(SPR_W);
  localparam int ROW_W       = $clog2(SPR_H);

  typedef logic [PIX_W-1:0] pix_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  // Frames are stored back to back, so a row starts at a constant-multiple offset.
  function automatic logic [ADDR_W-1:0] row_base(input logic [1:0] frame,
                                                 input logic [ROW_W-1:0] row);
    return ADDR_W'(frame * FRAME_WORDS) + ADDR_W'(row * SPR_W);
  endfunction
endpackage

// File: rtl/sprite_line_buffer.sv
// One sprite row of palette indices: synchronous write, combinational read, no reset.
module sprite_line_buffer
  import flappy_sprite_pkg::*;
(
  input  logic             Clk,
  input  logic             we,
  input  logic [COL_W-1:0] waddr,
  input  pix_idx_t         wdata,
  input  logic [COL_W-1:0] raddr,
  output pix_idx_t         rdata
);
  pix_idx_t mem [SPR_W];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = (raddr < COL_W'(SPR_W)) ? mem[raddr] : '0;
endmodule

// File: rtl/sprite_row_fetcher.sv
// Fetches one sprite row from ROM during hblank and serves palette indices per DrawX.
//  state | meaning
//  IDLE  | waiting for hblank_start; rom_addr holds its last value
//  FETCH | issuing one ROM address per cycle, writing the previous word
//  DRAIN | writing the final word, then marking the line valid
module sprite_row_fetcher
  import flappy_sprite_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               hblank_start,
  input  logic [COORD_W-1:0] next_line,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic [1:0]         frame_sel,
  input  logic [COORD_W-1:0] DrawX,
  output logic [ADDR_W-1:0]  rom_addr,
  input  pix_idx_t           rom_data,
  output logic               pixel_on,
  output pix_idx_t           pixel_idx,
  output logic               busy
);
  fetch_state_t        state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q;
  logic [1:0]          frame_q, frame_clamp;
  logic [COORD_W-1:0]  spr_x_q;
  logic                line_valid_q, line_valid_d;
  logic [ADDR_W-1:0]   rom_addr_d;
  logic                accept;
  logic signed [COORD_W:0] row_s, dx_s;
  logic                row_hit, dx_hit, hit;
  logic                buf_we;
  logic [COL_W-1:0]    buf_waddr;
  pix_idx_t            buf_rdata;

  assign frame_clamp = (frame_sel >= 2'(FRAMES)) ? 2'(FRAMES - 1) : frame_sel;
  assign row_s   = $signed({1'b0, next_line}) - $signed({1'b0, sprite_y});
  assign row_hit = !row_s[COORD_W] && (row_s[COORD_W-1:0] < COORD_W'(SPR_H));
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    rom_addr_d   = rom_addr;
    line_valid_d = line_valid_q;
    accept       = 1'b0;
    buf_we       = 1'b0;
    buf_waddr    = col_q - COL_W'(1);
    case (state_q)
      IDLE: begin
        if (hblank_start) begin
          accept       = 1'b1;
          line_valid_d = 1'b0;
          if (row_hit) begin
            state_d    = FETCH;
            col_d      = '0;
            rom_addr_d = row_base(frame_clamp, row_s[ROW_W-1:0]);
          end
        end
      end
      FETCH: begin
        // Word for col-1 lands this cycle; col 0 has nothing in flight yet.
        buf_we = (col_q != '0);
        if (col_q == COL_W'(SPR_W - 1)) begin
          state_d = DRAIN;
        end else begin
          col_d      = col_q + COL_W'(1);
          rom_addr_d = row_base(frame_q, row_q) + ADDR_W'(col_q) + ADDR_W'(1);
        end
      end
      DRAIN: begin
        buf_we       = 1'b1;
        buf_waddr    = COL_W'(SPR_W - 1);
        line_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      frame_q      <= '0;
      spr_x_q      <= '0;
      line_valid_q <= 1'b0;
      rom_addr     <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_valid_q <= line_valid_d;
      rom_addr     <= rom_addr_d;
      if (accept) begin
        spr_x_q <= sprite_x;
        frame_q <= frame_clamp;
      end
      if (accept && row_hit) row_q <= row_s[ROW_W-1:0];
    end
  end

  sprite_line_buffer u_buf (
    .Clk   (Clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (rom_data),
    .raddr (dx_s[COL_W-1:0]),
    .rdata (buf_rdata)
  );

  assign dx_s   = $signed({1'b0, DrawX}) - $signed({1'b0, spr_x_q});
  assign dx_hit = !dx_s[COORD_W] && (dx_s[COORD_W-1:0] < COORD_W'(SPR_W));
  assign hit    = line_valid_q && dx_hit && (buf_rdata != '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixel_on  <= 1'b0;
      pixel_idx <= '0;
    end else begin
      pixel_on  <= hit;
      pixel_idx <= hit ? buf_rdata : '0;
    end
  end
endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Scoreboard bench: stimulus queues expected ROM addresses and pixels, monitor compares.
module tb_sprite_row_fetcher;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       hblank_start = 1'b0;
  logic [9:0] next_line = '0, sprite_x = '0, sprite_y = '0, DrawX = '0;
  logic [1:0] frame_sel = '0;
  logic [9:0] rom_addr;
  logic [5:0] rom_data = '0;
  logic       pixel_on;
  logic [5:0] pixel_idx;
  logic       busy;

  sprite_row_fetcher dut (
    .Clk(Clk), .Reset_n(Reset_n), .hblank_start(hblank_start), .next_line(next_line),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_sel(frame_sel), .DrawX(DrawX),
    .rom_addr(rom_addr), .rom_data(rom_data), .pixel_on(pixel_on), .pixel_idx(pixel_idx),
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [5:0] rom_word(input int n);
    if (n % 17 == 5) return 6'd0;
    return 6'((n % 63) + 1);
  endfunction

  always @(posedge Clk) rom_data <= rom_word(int'(rom_addr));

  typedef struct {
    int         x;
    logic       on;
    logic [5:0] idx;
  } pix_exp_t;

  pix_exp_t   pix_q[$];
  int         addr_q[$];
  int         checks = 0;
  int         errors = 0;
  int         busy_cycles = 0;
  logic       sample_req = 1'b0;
  logic       req_d = 1'b0;

  logic [5:0] m_line [17];
  logic       m_lv = 1'b0;
  int         m_sx = 0;
  int         m_last = 0;

  always @(posedge Clk) req_d <= sample_req;

  always @(negedge Clk) begin
    pix_exp_t e;
    int       a;
    if (req_d) begin
      checks++;
      if (pix_q.size() == 0) begin
        errors++;
        $display("FAIL pix_underflow: DUT pixel with nothing expected");
      end else begin
        e = pix_q.pop_front();
        if (pixel_on !== e.on || pixel_idx !== e.idx) begin
          errors++;
          $display("FAIL pixel DrawX=%0d got on=%0b idx=%0d want on=%0b idx=%0d",
                   e.x, pixel_on, pixel_idx, e.on, e.idx);
        end
      end
    end
    if (busy === 1'b1) begin
      busy_cycles++;
      if (addr_q.size() != 0) begin
        a = addr_q.pop_front();
        checks++;
        if (rom_addr !== 10'(a)) begin
          errors++;
          $display("FAIL rom_addr got %0d want %0d", rom_addr, a);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic sweep(input int lo, input int hi);
    for (int x = lo; x <= hi; x++) begin
      pix_exp_t e;
      int       dx;
      @(negedge Clk);
      DrawX = 10'(x);
      dx    = x - m_sx;
      e.x   = x;
      e.on  = 1'b0;
      e.idx = 6'd0;
      if (m_lv && dx >= 0 && dx < 17) begin
        if (m_line[dx] != 6'd0) begin
          e.on  = 1'b1;
          e.idx = m_line[dx];
        end
      end
      pix_q.push_back(e);
      sample_req = 1'b1;
    end
    @(negedge Clk);
    sample_req = 1'b0;
    @(negedge Clk);
    check("pix_queue_drained", pix_q.size(), 0);
  endtask

  // base < 0 means the line misses the sprite and no fetch is expected.
  task automatic do_fetch(input int sy, input int nl, input int fsel, input int sx,
                          input int base, input bit glitch);
    @(negedge Clk);
    sprite_y     = 10'(sy);
    next_line    = 10'(nl);
    frame_sel    = 2'(fsel);
    sprite_x     = 10'(sx);
    hblank_start = 1'b1;
    busy_cycles  = 0;
    if (base >= 0) for (int k = 0; k < 17; k++) addr_q.push_back(base + k);
    m_sx = sx;
    m_lv = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge Clk);
      hblank_start = glitch && (i == 6);
      if (glitch && i == 6) begin
        next_line = 10'(sy);
        frame_sel = 2'd2;
        sprite_x  = 10'(sx + 7);
      end
    end
    check("busy_cycles", busy_cycles, (base >= 0) ? 18 : 0);
    check("addr_queue_drained", addr_q.size(), 0);
    if (base >= 0) begin
      for (int k = 0; k < 17; k++) m_line[k] = rom_word(base + k);
      m_lv   = 1'b1;
      m_last = base + 16;
    end
    check("rom_addr_hold", int'(rom_addr), m_last);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check("reset_busy", int'(busy), 0);
    check("reset_rom_addr", int'(rom_addr), 0);
    check("reset_pixel_on", int'(pixel_on), 0);
    check("reset_pixel_idx", int'(pixel_idx), 0);
    Reset_n = 1'b1;

    do_fetch(100, 103, 1, 300, 255, 1'b0);
    sweep(295, 320);

    do_fetch(100, 105, 0, 200, 85, 1'b1);
    sweep(195, 220);

    do_fetch(100, 99, 0, 300, -1, 1'b0);
    sweep(295, 320);
    do_fetch(100, 112, 0, 300, -1, 1'b0);
    sweep(295, 320);

    do_fetch(100, 100, 3, 630, 408, 1'b0);
    sweep(625, 639);

    // Reset in the middle of a fetch, with col = 8 on the address bus.
    @(negedge Clk);
    sprite_y = 10'd100; next_line = 10'd103; frame_sel = 2'd1; sprite_x = 10'd300;
    hblank_start = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge Clk);
      hblank_start = 1'b0;
    end
    check("midfetch_addr_col8", int'(rom_addr), 263);
    #2 Reset_n = 1'b0;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_rom_addr", int'(rom_addr), 0);
    check("midreset_pixel_on", int'(pixel_on), 0);
    addr_q.delete();
    @(negedge Clk);
    Reset_n     = 1'b1;
    m_lv        = 1'b0;
    m_last      = 0;
    busy_cycles = 0;
    repeat (10) @(negedge Clk);
    check("postreset_busy_cycles", busy_cycles, 0);
    check("postreset_rom_addr", int'(rom_addr), 0);
    sweep(295, 320);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
